// File: rtl/ntt_arith_pkg.sv
// Shared NTT arithmetic constants and types for the default modulus.
// barrett_ref is a plain-division golden reference for residues.
package ntt_arith_pkg;

  localparam int unsigned       Q  = 12289;
  localparam int unsigned       K  = $clog2(Q);
  localparam longint unsigned   MU = (64'd1 << (2 * K)) / Q;

  typedef logic [K-1:0]   coeff_t;
  typedef logic [2*K-1:0] wide_t;

  function automatic coeff_t barrett_ref(input wide_t x);
    return coeff_t'(x % wide_t'(Q));
  endfunction

endpackage

// File: rtl/barrett_lane.sv
// One lane of the Barrett multiply/reduce pipeline: S0 operand select,
// S1 quotient estimate, S2 partial remainder, S3 final correction.
module barrett_lane #(
  parameter int unsigned Q = ntt_arith_pkg::Q,
  parameter int unsigned K = $clog2(Q)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_mode,
  input  logic [K-1:0]   i_a,
  input  logic [K-1:0]   i_b,
  input  logic [2*K-1:0] i_x,
  output logic [K-1:0]   o_z,
  output logic           o_ovf
);

  localparam logic [2*K:0]   POW2 = {1'b1, {(2*K){1'b0}}};
  localparam logic [2*K:0]   QE   = (2*K+1)'(Q);
  localparam logic [K+1:0]   MU   = (K+2)'(POW2 / QE);
  localparam logic [2*K-1:0] QW   = (2*K)'(Q);
  localparam logic [2*K-1:0] QSQ  = QW * QW;
  localparam logic [K+1:0]   Q1   = (K+2)'(Q);
  localparam logic [K+1:0]   Q2   = Q1 << 1;

  logic [2*K-1:0] w_x0;
  logic           w_ovf0;
  logic [K:0]     w_q1;
  logic [2*K+2:0] w_q2;
  logic [K:0]     w_q3;
  logic [K+1:0]   w_p;
  logic [K+1:0]   w_r;

  logic [2*K-1:0] r_x0;
  logic [K+1:0]   r_x1;
  logic [K:0]     r_q3;
  logic [K+1:0]   r_r2;
  logic [K-1:0]   r_z;
  logic [3:0]     r_ovf;

  assign w_x0   = i_mode ? i_x : ({{K{1'b0}}, i_a} * {{K{1'b0}}, i_b});
  assign w_ovf0 = i_mode & (i_x >= QSQ);

  assign w_q1 = r_x0[2*K-1:K-1];
  assign w_q2 = {{(K+2){1'b0}}, w_q1} * {{(K+1){1'b0}}, MU};
  assign w_q3 = (K+1)'(w_q2 >> (K+1));

  // r < 3Q < 2^(K+2), so only the low K+2 bits of x and q3*Q matter
  assign w_p = {1'b0, r_q3} * Q1;
  assign w_r = r_x1 - w_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0  <= '0;
      r_x1  <= '0;
      r_q3  <= '0;
      r_r2  <= '0;
      r_z   <= '0;
      r_ovf <= '0;
    end else if (i_en) begin
      r_x0  <= w_x0;
      r_x1  <= r_x0[K+1:0];
      r_q3  <= w_q3;
      r_r2  <= w_r;
      r_ovf <= {r_ovf[2:0], w_ovf0};
      if (r_r2 >= Q2)      r_z <= K'(r_r2 - Q2);
      else if (r_r2 >= Q1) r_z <= K'(r_r2 - Q1);
      else                 r_z <= K'(r_r2);
    end
  end

  assign o_z   = r_z;
  assign o_ovf = r_ovf[3];

endmodule

// File: rtl/barrett_mulred_pipe.sv
// Multi-lane pipelined modular multiply/reduce with valid/ready handshake.
// Owns the stage-valid chain and tag pipeline; lanes hold the datapath.
module barrett_mulred_pipe #(
  parameter int unsigned Q         = ntt_arith_pkg::Q,
  parameter int unsigned Q_WIDTH   = $clog2(Q),
  parameter int unsigned LANES     = 4,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [LANES*Q_WIDTH-1:0]     in_a,
  input  logic [LANES*Q_WIDTH-1:0]     in_b,
  input  logic [LANES*2*Q_WIDTH-1:0]   in_x,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*Q_WIDTH-1:0]     out_z,
  output logic [LANES-1:0]             out_ovf,
  output logic [TAG_WIDTH-1:0]         out_tag
);

  logic                 w_adv;
  logic [3:0]           r_v;
  logic [TAG_WIDTH-1:0] r_tag [4];

  // Whole pipe moves as one; bubbles are kept so latency stays fixed
  assign w_adv     = ~r_v[3] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[3];
  assign out_tag   = r_tag[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int unsigned i = 0; i < 4; i++) r_tag[i] <= '0;
    end else if (w_adv) begin
      r_v      <= {r_v[2:0], in_valid};
      r_tag[0] <= in_tag;
      for (int unsigned i = 1; i < 4; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    barrett_lane #(
      .Q (Q),
      .K (Q_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_adv),
      .i_mode (in_mode),
      .i_a    (in_a[g*Q_WIDTH +: Q_WIDTH]),
      .i_b    (in_b[g*Q_WIDTH +: Q_WIDTH]),
      .i_x    (in_x[g*2*Q_WIDTH +: 2*Q_WIDTH]),
      .o_z    (out_z[g*Q_WIDTH +: Q_WIDTH]),
      .o_ovf  (out_ovf[g])
    );
  end

endmodule

// File: tb/tb_barrett_mulred_pipe.sv
// Bench for barrett_mulred_pipe: directed vector table, random streams,
// backpressure and reset corners, all checked through an in-order scoreboard.
module tb_barrett_mulred_pipe;
  import ntt_arith_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned TW    = 8;
  localparam int unsigned ZW    = LANES * K;
  localparam int unsigned XW    = LANES * 2 * K;

  typedef struct {
    logic [ZW-1:0]    z;
    logic [ZW-1:0]    zmask;
    logic [LANES-1:0] ovf;
    logic [TW-1:0]    tag;
  } exp_t;

  typedef struct {
    logic             mode;
    logic [ZW-1:0]    a;
    logic [ZW-1:0]    b;
    logic [XW-1:0]    x;
    logic [TW-1:0]    tag;
    logic [ZW-1:0]    z;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] zchk;
  } vec_t;

  logic             clk, rst;
  logic             in_valid, in_ready, in_mode;
  logic [ZW-1:0]    in_a, in_b;
  logic [XW-1:0]    in_x;
  logic [TW-1:0]    in_tag;
  logic             out_valid, out_ready;
  logic [ZW-1:0]    out_z;
  logic [LANES-1:0] out_ovf;
  logic [TW-1:0]    out_tag;

  exp_t        sb[$];
  exp_t        drv_exp;
  vec_t        vt[6];
  int unsigned n_cmp, n_bad, n_out, n_stall;
  bit          rdy_rand;
  logic        prev_stall;
  logic [ZW-1:0]    prev_z;
  logic [TW-1:0]    prev_tag;
  logic [LANES-1:0] prev_ovf;

  barrett_mulred_pipe #(
    .Q         (Q),
    .Q_WIDTH   (K),
    .LANES     (LANES),
    .TAG_WIDTH (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ZW-1:0] lane_mask(input logic [LANES-1:0] m);
    logic [ZW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*K +: K] = {K{m[i]}};
    return r;
  endfunction

  function automatic logic [ZW-1:0] pk(input int unsigned v0, v1, v2, v3);
    logic [ZW-1:0] r;
    int unsigned v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < LANES; i++) r[i*K +: K] = K'(v[i]);
    return r;
  endfunction

  function automatic logic [XW-1:0] pkx(input int unsigned v0, v1, v2, v3);
    logic [XW-1:0] r;
    int unsigned v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < LANES; i++) r[i*2*K +: 2*K] = (2*K)'(v[i]);
    return r;
  endfunction

  // Scoreboard monitor: transfers are decided by values held stable across the negedge
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_z", 64'(out_z), 64'(prev_z));
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
        chk("hold_ovf", 64'(out_ovf), 64'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("spurious_beat", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("z", 64'(out_z & e.zmask), 64'(e.z & e.zmask));
          chk("ovf", 64'(out_ovf), 64'(e.ovf));
          chk("tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) sb.push_back(drv_exp);
      prev_stall = out_valid && !out_ready;
      prev_z     = out_z;
      prev_tag   = out_tag;
      prev_ovf   = out_ovf;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic mode, input logic [ZW-1:0] a, input logic [ZW-1:0] b,
                      input logic [XW-1:0] x, input logic [TW-1:0] tag, input exp_t e);
    int unsigned guard;
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    in_x     = x;
    in_tag   = tag;
    drv_exp  = e;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n_stall++;
      guard++;
      if (guard > 500) begin
        chk("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    exp_t e;
    e.z     = v.z;
    e.zmask = lane_mask(v.zchk);
    e.ovf   = v.ovf;
    e.tag   = v.tag;
    send(v.mode, v.a, v.b, v.x, v.tag, e);
  endtask

  task automatic send_rand(input logic [TW-1:0] tag);
    logic          mode;
    logic [ZW-1:0] a, b;
    logic [XW-1:0] x;
    exp_t          e;
    wide_t         xv;
    int unsigned   av, bv, xr;
    mode = 1'($urandom_range(0, 1));
    a = '0; b = '0; x = '0;
    e.z = '0;
    for (int i = 0; i < LANES; i++) begin
      av = $urandom_range(0, Q - 1);
      bv = $urandom_range(0, Q - 1);
      xr = $urandom_range(0, Q * Q - 1);
      a[i*K +: K]     = K'(av);
      b[i*K +: K]     = K'(bv);
      x[i*2*K +: 2*K] = (2*K)'(xr);
      xv = mode ? wide_t'(xr) : wide_t'(av) * wide_t'(bv);
      e.z[i*K +: K] = barrett_ref(xv);
    end
    e.zmask = '1;
    e.ovf   = '0;
    e.tag   = tag;
    send(mode, a, b, x, tag, e);
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, o0;
    n_cmp = 0; n_bad = 0; n_out = 0; n_stall = 0;
    rdy_rand = 1'b0; prev_stall = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    in_a = '0; in_b = '0; in_x = '0; in_tag = '0;
    out_ready = 1'b1;
    drv_exp = '{default: '0};

    vt[0] = '{1'b0, pk(12288, 12288, 12288, 12288), pk(12288, 12288, 12288, 12288), '0,
              8'h5A, pk(1, 1, 1, 1), 4'b0000, 4'b1111};
    vt[1] = '{1'b1, '0, '0, pkx(0, 12289, 24578, 151019520),
              8'h11, pk(0, 0, 0, 12288), 4'b0000, 4'b1111};
    vt[2] = '{1'b1, '0, '0, pkx(151019521, 5, 151019520, 12288),
              8'h22, pk(0, 5, 12288, 12288), 4'b0001, 4'b1110};
    vt[3] = '{1'b0, pk(0, 1, 2, 6144), pk(12288, 12288, 6145, 2), '0,
              8'h33, pk(0, 12288, 1, 12288), 4'b0000, 4'b1111};
    vt[4] = '{1'b1, '0, '0, pkx(24577, 36867, 1, 24576),
              8'h44, pk(12288, 0, 1, 12287), 4'b0000, 4'b1111};
    vt[5] = '{1'b1, '0, '0, pkx(268435455, 268435455, 268435455, 268435455),
              8'hFF, '0, 4'b1111, 4'b0000};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_z", 64'(out_z), 64'd0);
    chk("reset_out_ovf", 64'(out_ovf), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single beat: measure accept-to-output latency
    send_vec(vt[0]);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    drain();

    for (int i = 1; i < 6; i++) send_vec(vt[i]);
    drain();

    n_stall = 0;
    o0 = n_out;
    for (int i = 0; i < 1000; i++) send_rand(TW'(i));
    drain();
    chk("stream_stalls", 64'(n_stall), 64'd0);
    chk("stream_count", 64'(n_out - o0), 64'd1000);

    rdy_rand = 1'b1;
    o0 = n_out;
    for (int i = 0; i < 300; i++) begin
      send_rand(TW'(i + 7));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("bp_count", 64'(n_out - o0), 64'd300);
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_vec(vt[i]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    for (int i = 0; i < 3; i++) send_rand(TW'(8'hA0 + i));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    o0 = n_out;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale", 64'(n_out - o0), 64'd0);
    @(posedge clk);
    #1;
    send_vec(vt[3]);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
